data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the pipeline's data-memory interface: accepts load requests and held store requests from the Memory stage, services them against an internal word-organised RAM with fixed, parameterised latency, and returns `loadData`/`loadDataValid` or pulses `storeComplete`. It sits between the Memory stage and the SoC data port and serialises one access at a time. Returned load data is the raw aligned word; byte/half extraction stays in the Memory stage.

## Interface
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0001_0000: byte address of word 0.
- `LOAD_LATENCY`, 2: cycles from load acceptance to `loadDataValid`; range 1..15.
- `STORE_LATENCY`, 1: cycles from store acceptance to `storeComplete`; range 1..15.
- `CONSOLE_ADDR`, 32'h0000_F000: console byte address (only with `DMEM_CONSOLE_EN`).

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `loadRequest` in 1: load wanted at `address`; level, held until `loadDataValid` or dropped on flush.
- `address` in 32: byte address; bits [1:0] ignored.
- `storeValid` in 1: store request; held high until the edge where `storeComplete` is high.
- `storeData` in 32: lane-aligned store data.
- `realStoreByteEnable` in 4: per-byte write enables.
- `loadData` out 32: aligned word; valid only while `loadDataValid`.
- `loadDataValid` out 1: one-cycle load response pulse.
- `storeComplete` out 1: one-cycle store acknowledge pulse.
- `accessFault` out 1: pulses with the response of an out-of-range access.
- `consoleValid` out 1, `consoleByte` out 8: console output (only with `DMEM_CONSOLE_EN`).

## Operation
- FSM: IDLE, LOAD_WAIT, STORE_WAIT, RESPOND. 4-bit down-counter `remaining`.
- IDLE: `storeValid` high -> capture address/data/enables, `remaining = STORE_LATENCY-1`, go STORE_WAIT. Else `loadRequest` high -> capture address, `remaining = LOAD_LATENCY-1`, go LOAD_WAIT. Store wins when both high.
- LOAD_WAIT: `remaining` decrements each cycle; at 0 read RAM at captured word index, drive `loadData`, `loadDataValid=1`, go RESPOND. If `loadRequest` low in any LOAD_WAIT cycle: abandon, no pulse, go IDLE.
- STORE_WAIT: at `remaining == 0` assert `storeComplete`, write enabled bytes on that edge, go RESPOND. Stores are never abandoned; `storeValid` is not re-sampled.
- RESPOND: one dead cycle, all pulses low, go IDLE. Guarantees the requester has retired/cleared its request before re-sampling.
- In range: `(address - BASE_ADDR) < DEPTH_WORDS*4` (32-bit unsigned, wrap-around underflow counts as out of range). Word index = `(address - BASE_ADDR) >> 2`.
- Out of range load: `loadData = 0`, `accessFault=1` with `loadDataValid`. Out of range store: no write, `accessFault=1` with `storeComplete`.
- Byte enable 4'b0000 store: completes normally, RAM unchanged.

## Timing
- Load acceptance at edge E0; `loadDataValid` high during cycle E0+LOAD_LATENCY; next acceptance no earlier than edge E0+LOAD_LATENCY+2.
- Store acceptance at E0; `storeComplete` high during cycle E0+STORE_LATENCY; RAM updated at the end of that cycle; a load accepted afterwards sees new data.
- Reset (`reset==0` at rising edge): state IDLE, `loadData=0`, `loadDataValid=0`, `storeComplete=0`, `accessFault=0`, `consoleValid=0`, `consoleByte=0`. In-flight accesses dropped, no pulse; RAM contents not cleared. Applies mid-operation identically.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `DMEM_CONSOLE_EN` defined: a store whose word address equals `CONSOLE_ADDR & ~3` is diverted from the RAM. On its `storeComplete` cycle, `consoleValid=1` and `consoleByte` = the lowest enabled byte lane of `storeData`. No `accessFault`. Loads from that word return 0 without fault.
- Undefined: console ports tied to 0; that address follows the normal range rule (out of range for defaults -> fault).

## Test plan
- Store 32'hDEADBEEF, enables 4'b1111 to 32'h0001_0010; load same -> `storeComplete` in cycle E0+1; `loadData=32'hDEADBEEF` in cycle E0'+2, `accessFault=0`.
- Store `storeData=32'h00AB_0000`, enables 4'b0100 onto word 32'h1111_1111 -> reload returns 32'h11AB_1111.
- Load from 32'h0000_0100 (below base) -> `loadData=0`, `loadDataValid` and `accessFault` together; store to 32'h0001_4000 -> `storeComplete`+`accessFault`, RAM unchanged.
- `loadRequest` and `storeValid` high same cycle -> store serviced first; load answered after RESPOND+IDLE with post-store data.
- `loadRequest` dropped one cycle after acceptance (LOAD_LATENCY=2) -> no `loadDataValid`; `reset` low mid-STORE_WAIT -> no `storeComplete`, word unchanged.
- With `DMEM_CONSOLE_EN`: byte store 32'h0000_0041, enables 4'b0001 to `CONSOLE_ADDR` -> `consoleValid=1`, `consoleByte=8'h41` with `storeComplete`, no fault.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the Memory stage (master)
// and the data-memory responder (slave). Console signals are only driven
// with meaning when the responder is built with DMEM_CONSOLE_EN.
interface data_memory_responder_if;
    logic        loadRequest;
    logic [31:0] address;
    logic        storeValid;
    logic [31:0] storeData;
    logic [3:0]  realStoreByteEnable;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        storeComplete;
    logic        accessFault;
    logic        consoleValid;
    logic [7:0]  consoleByte;

    modport master (
        output loadRequest, address, storeValid, storeData, realStoreByteEnable,
        input  loadData, loadDataValid, storeComplete, accessFault, consoleValid, consoleByte
    );

    modport slave (
        input  loadRequest, address, storeValid, storeData, realStoreByteEnable,
        output loadData, loadDataValid, storeComplete, accessFault, consoleValid, consoleByte
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: serialises one load or store at a time against an
// internal word RAM with fixed load/store latency. Loads return the raw
// aligned word; out-of-range accesses answer with accessFault.
// Optional feature macro: DMEM_CONSOLE_EN diverts stores to the console word
// onto consoleValid/consoleByte instead of the RAM.
module data_memory_responder #(
    parameter int          DEPTH_WORDS   = 4096,
    parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
    parameter int          LOAD_LATENCY  = 2,
    parameter int          STORE_LATENCY = 1
`ifdef DMEM_CONSOLE_EN
    ,
    parameter logic [31:0] CONSOLE_ADDR  = 32'h0000_F000
`endif
) (
    input  logic                          clock,
    input  logic                          reset,
    data_memory_responder_if.slave        bus
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LD_INIT = 4'(LOAD_LATENCY - 1);
    localparam logic [3:0]  ST_INIT = 4'(STORE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT, RESPOND} state_t;

    state_t          state, state_nxt;
    logic [3:0]      remaining, remaining_nxt;
    logic            capture, load_done, store_done;
    logic [31:0]     req_addr, req_data;
    logic [3:0]      req_be;
    logic [31:0]     offset;
    logic            in_range, is_console;
    logic [AW-1:0]   word_idx;
    logic [31:0]     mem [DEPTH_WORDS];

    // Range test on the captured address; an address below the base wraps
    // to a huge offset and so lands out of range as well.
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign word_idx = offset[AW+1:2];

`ifdef DMEM_CONSOLE_EN
    assign is_console = (req_addr[31:2] == CONSOLE_ADDR[31:2]);
`else
    assign is_console = 1'b0;
`endif

    // State and latency counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= 4'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Next state: stores win over loads, loads can be abandoned, stores cannot.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        capture       = 1'b0;
        load_done     = 1'b0;
        store_done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.storeValid) begin
                    capture       = 1'b1;
                    remaining_nxt = ST_INIT;
                    state_nxt     = STORE_WAIT;
                end else if (bus.loadRequest) begin
                    capture       = 1'b1;
                    remaining_nxt = LD_INIT;
                    state_nxt     = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (!bus.loadRequest) begin
                    state_nxt = IDLE;
                end else if (remaining == 4'd0) begin
                    load_done = 1'b1;
                    state_nxt = RESPOND;
                end else begin
                    remaining_nxt = remaining - 4'd1;
                end
            end
            STORE_WAIT: begin
                if (remaining == 4'd0) begin
                    store_done = 1'b1;
                    state_nxt  = RESPOND;
                end else begin
                    remaining_nxt = remaining - 4'd1;
                end
            end
            RESPOND:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request capture; only meaningful while an access is in flight.
    always_ff @(posedge clock) begin
        if (capture) begin
            req_addr <= bus.address;
            req_data <= bus.storeData;
            req_be   <= bus.realStoreByteEnable;
        end
    end

    // Registered responses: one-cycle pulses, data forced to zero otherwise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.loadData      <= '0;
            bus.loadDataValid <= 1'b0;
            bus.storeComplete <= 1'b0;
            bus.accessFault   <= 1'b0;
        end else begin
            bus.loadDataValid <= load_done;
            bus.storeComplete <= store_done;
            bus.accessFault   <= (load_done || store_done) && !in_range && !is_console;
            bus.loadData      <= (load_done && in_range && !is_console) ? mem[word_idx] : '0;
        end
    end

    // RAM byte-lane write on the store completion edge; reset drops it.
    always_ff @(posedge clock) begin
        if (reset && store_done && in_range && !is_console) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) mem[word_idx][8*b +: 8] <= req_data[8*b +: 8];
            end
        end
    end

`ifdef DMEM_CONSOLE_EN
    logic [7:0] console_lane;

    // Lowest enabled byte lane of the store data (scan high to low, last wins).
    always_comb begin
        console_lane = 8'h00;
        for (int b = 3; b >= 0; b--) begin
            if (req_be[b]) console_lane = req_data[8*b +: 8];
        end
    end

    // Console output pulse alongside storeComplete.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.consoleValid <= 1'b0;
            bus.consoleByte  <= 8'h00;
        end else begin
            bus.consoleValid <= store_done && is_console;
            bus.consoleByte  <= (store_done && is_console) ? console_lane : 8'h00;
        end
    end
`else
    assign bus.consoleValid = 1'b0;
    assign bus.consoleByte  = 8'h00;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed cases from the
// test plan followed by random loads/stores against a word-array model.
module tb_data_memory_responder;
    localparam int          LL   = 2;
    localparam int          SL   = 1;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          NP   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_responder_if bus();

    data_memory_responder dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Address pool: in-range flags written out by hand from the memory map.
    logic [31:0] pool_a  [NP] = '{BASE + 32'h10, BASE, BASE + 32'h3FFC, BASE + 32'h2468,
                                  BASE + 32'h800, 32'h0000_0100, 32'h0001_4000, 32'hFFFF_FFF0};
    bit          pool_in [NP] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] model   [NP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic exp_fault);
        int cyc = 0;
        bit seen = 0;
        bus.address = a; bus.storeData = d; bus.realStoreByteEnable = be; bus.storeValid = 1'b1;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.storeComplete) seen = 1;
        end
        chk({tag, ".lat"}, 32'(cyc), 32'(SL + 1));
        chk({tag, ".flt"}, 32'(bus.accessFault), 32'(exp_fault));
        chk({tag, ".con"}, 32'(bus.consoleValid), 32'd0);
        @(posedge clk); @(negedge clk);
        bus.storeValid = 1'b0;
        chk({tag, ".pulse"}, 32'(bus.storeComplete), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_fault);
        int cyc = 0;
        bit seen = 0;
        bus.address = a; bus.loadRequest = 1'b1;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.loadDataValid) seen = 1;
        end
        chk({tag, ".lat"}, 32'(cyc), 32'(LL + 1));
        chk({tag, ".data"}, bus.loadData, exp_d);
        chk({tag, ".flt"}, 32'(bus.accessFault), 32'(exp_fault));
        @(posedge clk); @(negedge clk);
        bus.loadRequest = 1'b0;
        chk({tag, ".pulse"}, 32'(bus.loadDataValid), 32'd0);
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [31:0] d;
        logic [3:0]  be;
        int          k;

        bus.loadRequest = 1'b0; bus.address = '0; bus.storeValid = 1'b0;
        bus.storeData = '0; bus.realStoreByteEnable = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst.ldv", 32'(bus.loadDataValid), 32'd0);
        chk("rst.stc", 32'(bus.storeComplete), 32'd0);
        chk("rst.flt", 32'(bus.accessFault), 32'd0);
        chk("rst.ld",  bus.loadData, 32'd0);
        chk("rst.con", {23'd0, bus.consoleValid, bus.consoleByte}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Seed every in-range pool word so the model knows its contents.
        for (int i = 0; i < NP; i++) begin
            if (pool_in[i]) begin
                d = $urandom;
                do_store("init", pool_a[i], d, 4'b1111, 1'b0);
                model[i] = d;
            end
        end

        // Full-word store then load
        do_store("st_dead", BASE + 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
        model[0] = 32'hDEADBEEF;
        do_load("ld_dead", BASE + 32'h10, 32'hDEADBEEF, 1'b0);

        // Single byte-lane merge
        do_store("st_1111", pool_a[3], 32'h1111_1111, 4'b1111, 1'b0);
        do_store("st_ab", pool_a[3], 32'h00AB_0000, 4'b0100, 1'b0);
        model[3] = 32'h11AB_1111;
        do_load("ld_ab", pool_a[3], 32'h11AB_1111, 1'b0);

        // Out of range: below base, and one past the end (would alias word 0)
        do_load("ld_low", 32'h0000_0100, 32'h0, 1'b1);
        do_store("st_high", 32'h0001_4000, 32'hCAFEF00D, 4'b1111, 1'b1);
        do_load("ld_w0", BASE, model[1], 1'b0);

        // Zero byte enables: completes, RAM unchanged
        do_store("st_be0", pool_a[2], 32'h5555_AAAA, 4'b0000, 1'b0);
        do_load("ld_be0", pool_a[2], model[2], 1'b0);

        // Store and load requested together: store first, load sees new data
        bus.address = pool_a[4]; bus.storeData = 32'h0BAD_CAFE; bus.realStoreByteEnable = 4'b1111;
        bus.storeValid = 1'b1; bus.loadRequest = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.storeComplete) seen = 1;
        end
        chk("both.stlat", 32'(cyc), 32'(SL + 1));
        @(posedge clk); cyc++;
        @(negedge clk);
        bus.storeValid = 1'b0;
        model[4] = 32'h0BAD_CAFE;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.loadDataValid) seen = 1;
        end
        chk("both.ldlat", 32'(cyc), 32'(SL + LL + 3));
        chk("both.data", bus.loadData, model[4]);
        @(posedge clk); @(negedge clk);
        bus.loadRequest = 1'b0;

        // Load dropped one cycle after acceptance: no response
        bus.address = pool_a[0]; bus.loadRequest = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.loadRequest = 1'b0;
        seen = 0;
        repeat (LL + 4) begin
            @(negedge clk);
            if (bus.loadDataValid) seen = 1;
        end
        chk("abandon.ldv", 32'(seen), 32'd0);
        do_load("ld_after_ab", pool_a[0], model[0], 1'b0);

        // Reset in the middle of a store: no pulse, word untouched
        bus.address = pool_a[1]; bus.storeData = 32'h7777_7777; bus.realStoreByteEnable = 4'b1111;
        bus.storeValid = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0; bus.storeValid = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.storeComplete) seen = 1;
        end
        chk("rstmid.stc", 32'(seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid.flt", 32'(bus.accessFault), 32'd0);
        do_load("ld_rstmid", pool_a[1], model[1], 1'b0);

`ifdef DMEM_CONSOLE_EN
        // Console store: diverted, byte reported, no fault
        bus.address = 32'h0000_F000; bus.storeData = 32'h0000_0041; bus.realStoreByteEnable = 4'b0001;
        bus.storeValid = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.storeComplete) seen = 1;
        end
        chk("con.lat", 32'(cyc), 32'(SL + 1));
        chk("con.vld", 32'(bus.consoleValid), 32'd1);
        chk("con.byte", 32'(bus.consoleByte), 32'h41);
        chk("con.flt", 32'(bus.accessFault), 32'd0);
        @(posedge clk); @(negedge clk);
        bus.storeValid = 1'b0;
        do_load("ld_con", 32'h0000_F000, 32'h0, 1'b0);
`endif

        // Random traffic over the pool, low address bits scrambled
        repeat (60) begin
            k = $urandom_range(0, NP - 1);
            if ($urandom_range(0, 1) == 1) begin
                d  = $urandom;
                be = 4'($urandom_range(0, 15));
                do_store("rnd_st", pool_a[k] | 32'($urandom_range(0, 3)), d, be, !pool_in[k]);
                if (pool_in[k]) model[k] = merge(model[k], d, be);
            end else begin
                do_load("rnd_ld", pool_a[k] | 32'($urandom_range(0, 3)),
                        pool_in[k] ? model[k] : 32'h0, !pool_in[k]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
